// File: rtl/mips_result_reporter_pkg.sv
// -----------------------------------------------------------------------------
// mips_result_reporter_pkg
// Shared definitions for the MIPS result reporter: FSM state encodings,
// default frame sync byte, and frame byte-index constants.
//
// Build option: define REPORTER_CHECKSUM_EN to append an XOR checksum byte
// (XOR of the six data bytes, SYNC excluded) after R3[7:0]; NBYTES becomes 8.
// -----------------------------------------------------------------------------
package mips_result_reporter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_SEND    = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

    localparam logic [2:0] IDX_SYNC  = 3'd0;
    localparam logic [2:0] IDX_R1_HI = 3'd1;
    localparam logic [2:0] IDX_R1_LO = 3'd2;
    localparam logic [2:0] IDX_R2_HI = 3'd3;
    localparam logic [2:0] IDX_R2_LO = 3'd4;
    localparam logic [2:0] IDX_R3_HI = 3'd5;
    localparam logic [2:0] IDX_R3_LO = 3'd6;

`ifdef REPORTER_CHECKSUM_EN
    localparam logic [2:0] IDX_CSUM  = 3'd7;
    localparam int         NBYTES    = 8;

    function automatic logic [7:0] frame_checksum(input logic [15:0] a,
                                                  input logic [15:0] b,
                                                  input logic [15:0] c);
        return a[15:8] ^ a[7:0] ^ b[15:8] ^ b[7:0] ^ c[15:8] ^ c[7:0];
    endfunction
`else
    localparam int         NBYTES    = 7;
`endif

    localparam logic [2:0] IDX_LAST  = 3'(NBYTES - 1);

endpackage

// File: rtl/mips_result_reporter_uart_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
// One 8N1 UART byte transmitter. Owns the bit timer (down-counter) and the
// shift register. A new start request is accepted while idle or during the
// last cycle of the stop bit, so consecutive bytes leave with no idle gap.
//
// Ports
//   clk        in   system clock, rising edge
//   clear      in   asynchronous active-high reset
//   start      in   load data and begin a byte
//   data[7:0]  in   byte to send, LSB first
//   tx         out  serial line, idle high
//   busy       out  byte in progress
//   done_pulse out  high during the final cycle of the stop bit
// -----------------------------------------------------------------------------
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done_pulse
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] BIT_RELOAD = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] r_timer;
    logic [3:0]    r_bit_idx;
    logic [8:0]    r_shift;
    logic          r_active;
    logic          r_tx;

    logic w_bit_end;
    logic w_last;

    assign w_bit_end  = (r_timer == '0);
    // bit index 9 is the stop bit
    assign w_last     = r_active && w_bit_end && (r_bit_idx == 4'd9);
    assign done_pulse = w_last;
    assign busy       = r_active;
    assign tx         = r_tx;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '1;
            r_active  <= 1'b0;
            r_tx      <= 1'b1;
        end else if (start && (!r_active || w_last)) begin
            r_active  <= 1'b1;
            r_tx      <= 1'b0;
            // data bits followed by the stop bit; shifted out LSB first
            r_shift   <= {1'b1, data};
            r_timer   <= BIT_RELOAD;
            r_bit_idx <= 4'd0;
        end else if (r_active) begin
            if (w_bit_end) begin
                if (r_bit_idx == 4'd9) begin
                    r_active <= 1'b0;
                    r_tx     <= 1'b1;
                end else begin
                    r_tx      <= r_shift[0];
                    r_shift   <= {1'b1, r_shift[8:1]};
                    r_bit_idx <= r_bit_idx + 4'd1;
                    r_timer   <= BIT_RELOAD;
                end
            end else begin
                r_timer <= r_timer - TW'(1);
            end
        end
    end

endmodule

// File: rtl/mips_result_reporter.sv
// -----------------------------------------------------------------------------
// mips_result_reporter
// Watches the MIPS core PC and R1/R2/R3 taps, detects halt (PC unchanged for
// HALT_CYCLES), snapshots the registers and sends one UART 8N1 frame:
//   SYNC, R1[15:8], R1[7:0], R2[15:8], R2[7:0], R3[15:8], R3[7:0] [, CSUM]
// Re-arms when PC leaves the halt address.
//
// Build option: REPORTER_CHECKSUM_EN adds the XOR checksum byte.
//
// Ports
//   clk     in   system clock, rising edge
//   clear   in   asynchronous active-high reset
//   pc      in   core program counter (6 bits)
//   r1..r3  in   result registers (16 bits each)
//   tx      out  UART serial out, idle high
//   busy    out  high from CAPTURE through the last stop bit
//   halted  out  halt detected (registered)
//   done    out  frame sent, held until re-arm
//
// state    | meaning
// ---------+----------------------------------------------------
// IDLE     | waiting for halted with no frame pending
// CAPTURE  | snapshot registers and halt PC, launch SYNC byte
// SEND     | streaming frame bytes back-to-back
// DONE     | frame sent; wait for PC to leave the halt address
// -----------------------------------------------------------------------------
module mips_result_reporter
    import mips_result_reporter_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         HALT_CYCLES  = 8,
    parameter logic [7:0] SYNC_BYTE    = DEF_SYNC_BYTE
) (
    input  logic        clk,
    input  logic        clear,
    input  logic [5:0]  pc,
    input  logic [15:0] r1,
    input  logic [15:0] r2,
    input  logic [15:0] r3,
    output logic        tx,
    output logic        busy,
    output logic        halted,
    output logic        done
);

    localparam int SW = $clog2(HALT_CYCLES);
    localparam logic [SW-1:0] STABLE_MAX = SW'(HALT_CYCLES - 1);

    state_t      r_state;
    logic [5:0]  r_pc_q;
    logic [5:0]  r_halt_pc;
    logic [SW-1:0] r_stable_cnt;
    logic        r_halted;
    logic        r_busy;
    logic        r_done;
    logic [2:0]  r_byte_idx;
    logic [15:0] r_snap_r1;
    logic [15:0] r_snap_r2;
    logic [15:0] r_snap_r3;

    logic        w_tx_start;
    logic [7:0]  w_tx_data;
    logic        w_tx_busy;
    logic        w_tx_done;
    logic [2:0]  w_next_idx;

    assign busy   = r_busy;
    assign halted = r_halted;
    assign done   = r_done;

    // Halt detect: counter saturates at HALT_CYCLES-1 so it never wraps.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_pc_q       <= '0;
            r_stable_cnt <= '0;
            r_halted     <= 1'b0;
        end else begin
            r_pc_q <= pc;
            if (pc != r_pc_q) begin
                r_stable_cnt <= '0;
                r_halted     <= 1'b0;
            end else begin
                if (r_stable_cnt != STABLE_MAX)
                    r_stable_cnt <= r_stable_cnt + SW'(1);
                if (r_stable_cnt == STABLE_MAX)
                    r_halted <= 1'b1;
            end
        end
    end

    // The byte being launched: SYNC from CAPTURE, otherwise the one after the
    // byte whose stop bit is ending.
    assign w_next_idx = (r_state == ST_CAPTURE) ? IDX_SYNC : (r_byte_idx + 3'd1);
    assign w_tx_start = (r_state == ST_CAPTURE) ||
                        ((r_state == ST_SEND) && w_tx_done && (r_byte_idx != IDX_LAST));

    always_comb begin
        w_tx_data = SYNC_BYTE;
        case (w_next_idx)
            IDX_R1_HI: w_tx_data = r_snap_r1[15:8];
            IDX_R1_LO: w_tx_data = r_snap_r1[7:0];
            IDX_R2_HI: w_tx_data = r_snap_r2[15:8];
            IDX_R2_LO: w_tx_data = r_snap_r2[7:0];
            IDX_R3_HI: w_tx_data = r_snap_r3[15:8];
            IDX_R3_LO: w_tx_data = r_snap_r3[7:0];
`ifdef REPORTER_CHECKSUM_EN
            IDX_CSUM:  w_tx_data = frame_checksum(r_snap_r1, r_snap_r2, r_snap_r3);
`endif
            default:   w_tx_data = SYNC_BYTE;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_byte_idx <= '0;
            r_halt_pc  <= '0;
            r_snap_r1  <= '0;
            r_snap_r2  <= '0;
            r_snap_r3  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_halted && !r_done && !w_tx_busy) begin
                        r_state <= ST_CAPTURE;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    r_snap_r1  <= r1;
                    r_snap_r2  <= r2;
                    r_snap_r3  <= r3;
                    r_halt_pc  <= r_pc_q;
                    r_byte_idx <= IDX_SYNC;
                    r_state    <= ST_SEND;
                end
                ST_SEND: begin
                    if (w_tx_done) begin
                        if (r_byte_idx == IDX_LAST) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_byte_idx <= r_byte_idx + 3'd1;
                        end
                    end
                end
                ST_DONE: begin
                    if (pc != r_halt_pc) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk       (clk),
        .clear     (clear),
        .start     (w_tx_start),
        .data      (w_tx_data),
        .tx        (tx),
        .busy      (w_tx_busy),
        .done_pulse(w_tx_done)
    );

endmodule
